run_controller: RTL and testbench
=================================

Name: run_controller

Overview:
- Synthesizable, parametrised successor to the hand-coded bench clock/reset sequence for the MIPS top.
- Sits between the bench (or FPGA board logic) and the processor core.
- Generates the core reset pulse of programmable length and a per-cycle clock enable.
- Bounds execution by cycle count or halt, supports free-run and single-step modes, and reports why a run ended.

Parameters:
- RESET_CYCLES, 1, cycles core_reset is held high after start (≥1)
- MAX_CYCLES, 16, enabled cycles before automatic stop; 0 = unlimited
- CNT_W, 16, width of cycle_count

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  begin a run; accepted only in IDLE or DONE
- mode_step  input  1  0 = free-run, 1 = single-step
- step  input  1  in single-step mode, each high cycle grants one enabled core cycle
- halt  input  1  core reports halted
- abort  input  1  terminate the run immediately
- core_reset  output  1  active-high reset to the processor core
- core_en  output  1  clock enable to the processor core
- cycle_count  output  CNT_W  enabled cycles in the current run
- running  output  1  high in RUN or STEP
- done  output  1  high in DONE
- done_cause  output  2  00 none, 01 max reached, 10 halt, 11 abort

Behaviour:
- reset low, at any time, asynchronously forces:
  - state = IDLE, core_reset = 1, core_en = 0
  - cycle_count = 0, running = 0, done = 0, done_cause = 00
- States: IDLE, RST, RUN, STEP, DONE.
- Output registering:
  - All outputs are registered except core_en.
  - core_en = (state==RUN) | (state==STEP & step), combinational.
- IDLE:
  - core_reset = 1, core_en = 0.
  - start → RST; reset-length counter loads RESET_CYCLES; cycle_count cleared.
- RST:
  - core_reset = 1 for exactly RESET_CYCLES clock cycles.
  - Then → RUN if mode_step = 0, else → STEP.
  - core_reset is 0 from the first RUN/STEP cycle onward.
- RUN:
  - core_en = 1 every cycle.
  - cycle_count increments on every edge where core_en = 1.
  - cycle_count saturates at all-ones and never wraps.
- STEP:
  - core_en follows step; cycle_count increments only on cycles where step = 1.
  - A step held high for k cycles grants k enabled cycles.
- Mode switching:
  - mode_step may change during RUN or STEP; the state switches RUN↔STEP at the next edge.
  - The cycle in which the change is sampled uses the old state's core_en.
- Termination, evaluated each cycle in RUN/STEP, with priority abort > halt > max:
  - abort = 1 → DONE, cause 11; abort also terminates from RST, cause 11.
  - halt = 1 → DONE, cause 10. An enabled cycle in which halt is sampled is still counted.
  - MAX_CYCLES ≠ 0 and the post-increment count equals MAX_CYCLES → DONE, cause 01. Exactly MAX_CYCLES enabled cycles occur.
- DONE:
  - core_en = 0, core_reset = 0, done = 1, running = 0.
  - cycle_count and done_cause hold.
  - start → RST, clearing done, done_cause and cycle_count (re-run).
  - abort and halt are ignored.
- start outside IDLE/DONE is ignored.
- abort in IDLE is ignored.
- halt already high when RUN is entered ends the run after the first enabled cycle, count = 1, cause 10.

Test Plan:
1. RESET_CYCLES=2, MAX_CYCLES=16: release reset, pulse start → core_reset high 2 cycles, then core_en high 16 consecutive cycles; done = 1, done_cause = 01, cycle_count = 16, core_en = 0 thereafter.
2. Free-run, halt asserted in the cycle where cycle_count reads 5 → that cycle is counted; DONE with cycle_count = 6, done_cause = 10.
3. mode_step = 1, three 1-cycle step pulses separated by 4 idle cycles, then one 2-cycle pulse → exactly 5 core_en cycles, each aligned with step; cycle_count = 5, running = 1.
4. abort during RST → next cycle DONE, done_cause = 11, core_reset = 0, cycle_count = 0; a new start re-runs cleanly with cause cleared.
5. reset driven low mid-RUN between clock edges → all outputs at reset values immediately, without a clock edge; start is needed to run again.
6. halt asserted in the cycle reaching MAX_CYCLES → done_cause = 10. With MAX_CYCLES=0 and CNT_W=4, a run continues past 15 with cycle_count saturated at 15.

Source files
------------

// File: rtl/run_controller.sv
// Run controller for the processor core: sequences the core reset pulse, gates the
// core clock enable, bounds a run by cycle count, halt or abort, and reports why it ended.
module run_controller #(
    parameter int RESET_CYCLES = 1,
    parameter int MAX_CYCLES   = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode_step,
    input  logic             step,
    input  logic             halt,
    input  logic             abort,
    output logic             core_reset,
    output logic             core_en,
    output logic [CNT_W-1:0] cycle_count,
    output logic             running,
    output logic             done,
    output logic [1:0]       done_cause
);

    localparam int RC_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_MAX   = 2'b01;
    localparam logic [1:0] CAUSE_HALT  = 2'b10;
    localparam logic [1:0] CAUSE_ABORT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_STEP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]       cause_q, cause_d;
    logic             core_reset_q, core_reset_d;
    logic             running_q, running_d;
    logic             done_q, done_d;

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        core_en   = (state_q == S_RUN) | ((state_q == S_STEP) & step);
        // Saturating increment: the count sticks at all-ones instead of wrapping.
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RST;
                    rst_cnt_d = RC_W'(RESET_CYCLES);
                    cnt_d     = '0;
                    cause_d   = CAUSE_NONE;
                end
            end
            S_RST: begin
                if (abort) begin
                    state_d = S_DONE;
                    cause_d = CAUSE_ABORT;
                end else if (rst_cnt_q == RC_W'(1)) begin
                    state_d = mode_step ? S_STEP : S_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - RC_W'(1);
                end
            end
            S_RUN, S_STEP: begin
                // The enabled cycle is counted even when the run ends on it.
                if (core_en) cnt_d = cnt_inc;
                if (abort) begin
                    state_d = S_DONE;
                    cause_d = CAUSE_ABORT;
                end else if (halt) begin
                    state_d = S_DONE;
                    cause_d = CAUSE_HALT;
                end else if ((MAX_CYCLES != 0) && core_en && (cnt_inc == CNT_W'(MAX_CYCLES))) begin
                    state_d = S_DONE;
                    cause_d = CAUSE_MAX;
                end else begin
                    state_d = mode_step ? S_STEP : S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are registered off the next state so they line up with it.
        core_reset_d = (state_d == S_IDLE) | (state_d == S_RST);
        running_d    = (state_d == S_RUN) | (state_d == S_STEP);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rst_cnt_q    <= '0;
            cnt_q        <= '0;
            cause_q      <= CAUSE_NONE;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            cnt_q        <= cnt_d;
            cause_q      <= cause_d;
            core_reset_q <= core_reset_d;
            running_q    <= running_d;
            done_q       <= done_d;
        end
    end

    assign core_reset  = core_reset_q;
    assign cycle_count = cnt_q;
    assign running     = running_q;
    assign done        = done_q;
    assign done_cause  = cause_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: two instances (bounded 16-bit and unbounded 4-bit) driven
// in lockstep and compared every cycle against a run-level behavioural model.
module tb_run_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, mode_step = 1'b0, step = 1'b0, halt = 1'b0, abort = 1'b0;

    logic        cr0, ce0, run0, dn0;
    logic [15:0] cc0;
    logic [1:0]  dc0;
    logic        cr1, ce1, run1, dn1;
    logic [3:0]  cc1;
    logic [1:0]  dc1;

    int total = 0;
    int bad   = 0;
    int en_seen = 0;

    always #5 clk = ~clk;

    run_controller #(.RESET_CYCLES(2), .MAX_CYCLES(16), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset(rst_n), .start(start), .mode_step(mode_step), .step(step),
        .halt(halt), .abort(abort), .core_reset(cr0), .core_en(ce0), .cycle_count(cc0),
        .running(run0), .done(dn0), .done_cause(dc0));

    run_controller #(.RESET_CYCLES(1), .MAX_CYCLES(0), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset(rst_n), .start(start), .mode_step(mode_step), .step(step),
        .halt(halt), .abort(abort), .core_reset(cr1), .core_en(ce1), .cycle_count(cc1),
        .running(run1), .done(dn1), .done_cause(dc1));

    // Model: a run is a phase plus counters; limits per instance.
    localparam int PH_IDLE = 0, PH_RST = 1, PH_ACT = 2, PH_DONE = 3;
    int rc_len[2]  = '{2, 1};
    int max_cyc[2] = '{16, 0};
    int sat[2]     = '{65535, 15};
    int ph[2], rst_left[2], cnt[2], cause[2];
    bit stepping[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit exp_en(input int i);
        return (ph[i] == PH_ACT) && (!stepping[i] || step);
    endfunction

    task automatic model_rst();
        for (int i = 0; i < 2; i++) begin
            ph[i] = PH_IDLE; rst_left[i] = 0; cnt[i] = 0; cause[i] = 0; stepping[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit e;
            e = exp_en(i);
            if (ph[i] == PH_IDLE || ph[i] == PH_DONE) begin
                if (start) begin ph[i] = PH_RST; rst_left[i] = rc_len[i]; cnt[i] = 0; cause[i] = 0; end
            end else if (ph[i] == PH_RST) begin
                if (abort) begin ph[i] = PH_DONE; cause[i] = 3; end
                else if (rst_left[i] == 1) begin ph[i] = PH_ACT; stepping[i] = mode_step; end
                else rst_left[i]--;
            end else begin
                if (e && cnt[i] < sat[i]) cnt[i]++;
                if (abort) begin ph[i] = PH_DONE; cause[i] = 3; end
                else if (halt) begin ph[i] = PH_DONE; cause[i] = 2; end
                else if (max_cyc[i] != 0 && e && cnt[i] == max_cyc[i]) begin ph[i] = PH_DONE; cause[i] = 1; end
                else stepping[i] = mode_step;
            end
        end
    endtask

    task automatic chk_inst(input int i, input logic cr, input logic ce, input logic [31:0] cc,
                            input logic rn, input logic dn, input logic [1:0] dc);
        chk($sformatf("core_reset%0d", i), cr, (ph[i] == PH_IDLE || ph[i] == PH_RST));
        chk($sformatf("core_en%0d", i), ce, exp_en(i));
        chk($sformatf("cycle_count%0d", i), cc, cnt[i]);
        chk($sformatf("running%0d", i), rn, ph[i] == PH_ACT);
        chk($sformatf("done%0d", i), dn, ph[i] == PH_DONE);
        chk($sformatf("done_cause%0d", i), dc, cause[i]);
    endtask

    // Drive one cycle's inputs (already past negedge), check, then advance the model.
    task automatic cyc_now(input logic s, input logic ms, input logic st, input logic h, input logic a);
        start = s; mode_step = ms; step = st; halt = h; abort = a;
        #1;
        if (ce0) en_seen++;
        chk_inst(0, cr0, ce0, 32'(cc0), run0, dn0, dc0);
        chk_inst(1, cr1, ce1, 32'(cc1), run1, dn1, dc1);
        model_step();
    endtask

    task automatic cyc(input logic s, input logic ms, input logic st, input logic h, input logic a);
        @(negedge clk);
        cyc_now(s, ms, st, h, a);
    endtask

    // Idle until the model says instance 0 will show `target`, then confirm it on the DUT.
    task automatic wait_cnt0(input int target, input logic ms);
        for (int k = 0; k < 200 && cnt[0] != target; k++) cyc(0, ms, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("wait_cnt0", 32'(cc0), target);
    endtask

    initial begin
        model_rst();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_core_reset", cr0, 1'b1);
        chk("rst_core_en", ce0, 1'b0);
        chk("rst_count", 32'(cc0), 0);
        chk("rst_running", run0, 1'b0);
        chk("rst_done", dn0, 1'b0);
        chk("rst_cause", dc0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);

        // Full bounded run: 2 reset cycles then 16 enabled cycles.
        cyc(1, 0, 0, 0, 0);
        en_seen = 0;
        repeat (25) cyc(0, 0, 0, 0, 0);
        chk("t1_en_cycles", en_seen, 16);
        chk("t1_count", 32'(cc0), 16);
        chk("t1_cause", dc0, 2'b01);
        chk("t1_done", dn0, 1'b1);
        chk("t1_sat_count", 32'(cc1), 15);
        chk("t1_sat_running", run1, 1'b1);

        // Halt sampled while count reads 5 is still counted.
        cyc(1, 0, 0, 0, 0);
        wait_cnt0(5, 0);
        cyc_now(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t2_count", 32'(cc0), 6);
        chk("t2_cause", dc0, 2'b10);

        // Single-step: 3 single pulses and one 2-cycle pulse.
        cyc(1, 1, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0);
        en_seen = 0;
        repeat (3) begin
            cyc(0, 1, 1, 0, 0);
            repeat (4) cyc(0, 1, 0, 0, 0);
        end
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("t3_en_cycles", en_seen, 5);
        chk("t3_count", 32'(cc0), 5);
        chk("t3_running", run0, 1'b1);
        chk("t3_count1", 32'(cc1), 5);
        cyc(0, 1, 0, 0, 1);

        // Abort during the reset phase, then a clean re-run.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("t4_done", dn0, 1'b1);
        chk("t4_cause", dc0, 2'b11);
        chk("t4_core_reset", cr0, 1'b0);
        chk("t4_count", 32'(cc0), 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t4_rerun_cause", dc0, 2'b00);
        chk("t4_rerun_done", dn0, 1'b0);
        chk("t4_rerun_core_reset", cr0, 1'b1);

        // Halt on the cycle that reaches the limit wins over the limit.
        wait_cnt0(15, 0);
        cyc_now(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t6_count", 32'(cc0), 16);
        chk("t6_cause", dc0, 2'b10);

        // Asynchronous reset mid-run, between edges.
        cyc(1, 0, 0, 0, 0);
        repeat (6) cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_core_reset", cr0, 1'b1);
        chk("t5_core_en", ce0, 1'b0);
        chk("t5_count", 32'(cc0), 0);
        chk("t5_running", run0, 1'b0);
        chk("t5_done", dn0, 1'b0);
        chk("t5_count1", 32'(cc1), 0);
        model_rst();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cyc(0, 0, 0, 0, 0);
        chk("t5_idle_running", run0, 1'b0);

        // Randomized traffic against the model.
        begin
            logic ms;
            ms = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(15) == 0) ms = ~ms;
                cyc($urandom_range(7) == 0, ms, 1'($urandom_range(1)),
                    $urandom_range(40) == 0, $urandom_range(80) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
